mem_arbiter: RTL and testbench

Two-client memory arbiter sitting directly below the instruction and data caches: it takes word requests from the icache and the dcache and drives a single RAM port. Dcache has priority and is given a locked two-word window so a block fill or writeback is not split by an instruction fetch. A starvation counter guarantees forward progress for the icache. Completion is signalled back to each cache on its wait line in the same cycle the RAM reports ACCESS.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) arbiter onto one RAM port with a dcache block lock and icache starvation guard.
// Optional statistics counters are built only when MEMARB_STATS_EN is defined.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 32
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic                                  iREN,
  input  logic [31:0]                           iaddr,
  output logic                                  iwait,
  output logic [31:0]                           iload,
  input  logic                                  dREN,
  input  logic                                  dWEN,
  input  logic [31:0]                           daddr,
  input  logic [31:0]                           dstore,
  output logic                                  dwait,
  output logic [31:0]                           dload,
  output logic                                  ramREN,
  output logic                                  ramWEN,
  output logic [31:0]                           ramaddr,
  output logic [31:0]                           ramstore,
  input  logic [31:0]                           ramload,
  input  logic [1:0]                            ramstate,
  output logic [CNT_W-1:0]                      dgrant_cnt,
  output logic [CNT_W-1:0]                      igrant_cnt,
  output logic [CNT_W-1:0]                      conflict_cnt,
  output logic [1:0]                            dbg_state,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]     dbg_starve_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBUSY = 2'd1,
    IBUSY = 2'd2,
    DHOLD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          dreq, starved, grant_d, grant_i, access, done_d, done_i;

  // A client's wait drops only in the cycle its granted word sees ACCESS.
  always_comb begin
    dreq    = dREN | dWEN;
    starved = iREN && (starve_q == SW'(STARVE_LIMIT));
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state_q)
      IDLE: begin
        if (starved)   grant_i = 1'b1;
        else if (dreq) grant_d = 1'b1;
        else if (iREN) grant_i = 1'b1;
      end
      DBUSY:   grant_d = dreq;
      IBUSY:   grant_i = iREN;
      DHOLD:   grant_d = dreq;
      default: ;
    endcase
    // Reset overrides any grant so the RAM sees idle strobes immediately.
    if (!nRST) begin
      grant_d = 1'b0;
      grant_i = 1'b0;
    end

    access = (ramstate == RS_ACCESS);
    done_d = grant_d & access;
    done_i = grant_i & access;

    state_d = IDLE;
    if (grant_d)      state_d = done_d ? (daddr[2] ? IDLE : DHOLD) : DBUSY;
    else if (grant_i) state_d = done_i ? IDLE : IBUSY;

    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (grant_d) begin
      ramREN   = dREN & ~dWEN;
      ramWEN   = dWEN;
      ramaddr  = daddr;
      ramstore = dstore;
    end else if (grant_i) begin
      ramREN  = 1'b1;
      ramaddr = iaddr;
    end
    iwait = ~done_i;
    dwait = ~done_d;

    starve_d = '0;
    if (iREN && !done_i)
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign iload          = ramload;
  assign dload          = ramload;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

`ifdef MEMARB_STATS_EN
  logic [CNT_W-1:0] dgrant_q, dgrant_d, igrant_q, igrant_d, conflict_q, conflict_d;

  always_comb begin
    dgrant_d   = dgrant_q + {{(CNT_W-1){1'b0}}, done_d};
    igrant_d   = igrant_q + {{(CNT_W-1){1'b0}}, done_i};
    conflict_d = conflict_q + {{(CNT_W-1){1'b0}}, iREN & grant_d};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dgrant_q   <= '0;
      igrant_q   <= '0;
      conflict_q <= '0;
    end else begin
      dgrant_q   <= dgrant_d;
      igrant_q   <= igrant_d;
      conflict_q <= conflict_d;
    end
  end

  assign dgrant_cnt   = dgrant_q;
  assign igrant_cnt   = igrant_q;
  assign conflict_cnt = conflict_q;
`else
  assign dgrant_cnt   = '0;
  assign igrant_cnt   = '0;
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the arbitration rules and a completion scoreboard.
module tb_mem_arbiter;
  localparam int LIMIT = 8;
  localparam int CW    = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [CW-1:0] dgrant_cnt, igrant_cnt, conflict_cnt;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .dgrant_cnt(dgrant_cnt), .igrant_cnt(igrant_cnt), .conflict_cnt(conflict_cnt),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // scoreboard: addresses of words the model says must complete, in order
  logic [31:0] exp_q[$];

  // reference model: who owns the port, whether the dcache block window is open
  int          m_owner;   // 0 nobody, 1 dcache, 2 icache (locked mid-transfer)
  bit          m_window;
  int          m_starve;
  logic [CW-1:0] m_dg, m_ig, m_cf;
  logic [31:0] obs_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_owner == 1) return 2'd1;
    if (m_owner == 2) return 2'd2;
    if (m_window)     return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_window = 0; m_starve = 0;
    m_dg = '0; m_ig = '0; m_cf = '0;
  endtask

  // driver: apply one cycle of inputs, check outputs mid-cycle, advance the model
  task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                      input bit dr, input bit dw, input logic [31:0] da,
                      input logic [31:0] ds, input logic [31:0] rl, input logic [1:0] rs);
    int who;
    bit done, dq, obs_done;
    logic e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;
    nRST = rst; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    if (!rst) model_reset();
    #2;
    chk("state", dbg_state, model_state());
    chk("starve", dbg_starve_cnt, m_starve);
`ifdef MEMARB_STATS_EN
    chk("dgrant_cnt", dgrant_cnt, m_dg);
    chk("igrant_cnt", igrant_cnt, m_ig);
    chk("conflict_cnt", conflict_cnt, m_cf);
`else
    chk("dgrant_cnt", dgrant_cnt, 0);
    chk("igrant_cnt", igrant_cnt, 0);
    chk("conflict_cnt", conflict_cnt, 0);
`endif
    dq = dr | dw;
    who = 0;
    if (rst) begin
      if (m_owner == 1)      who = dq ? 1 : 0;
      else if (m_owner == 2) who = ir ? 2 : 0;
      else if (m_window)     who = dq ? 1 : 0;
      else if (ir && m_starve == LIMIT) who = 2;
      else if (dq)           who = 1;
      else if (ir)           who = 2;
    end
    done    = (who != 0) && (rs == ACCESS);
    e_ren   = (who == 1) ? (dr & ~dw) : (who == 2);
    e_wen   = (who == 1) && dw;
    e_addr  = (who == 1) ? da : (who == 2) ? ia : 32'h0;
    e_store = (who == 1) ? ds : 32'h0;
    e_iw    = !((who == 2) && done);
    e_dw    = !((who == 1) && done);
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("iwait", iwait, e_iw);
    chk("dwait", dwait, e_dw);
    chk("iload", iload, rl);
    chk("dload", dload, rl);
    obs_addr = ramaddr;
    if (done) exp_q.push_back(e_addr);
    obs_done = !iwait || !dwait;
    if (obs_done) begin
      if (exp_q.size() == 0) chk("sb_unexpected_done", obs_done, 1'b0);
      else chk("sb_addr", ramaddr, exp_q.pop_front());
    end
    if (rst) begin
      if (who == 1 && done) m_dg = m_dg + 1;
      if (who == 2 && done) m_ig = m_ig + 1;
      if (ir && who == 1)   m_cf = m_cf + 1;
      m_starve = (ir && !(who == 2 && done)) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      if (who == 0)   begin m_owner = 0;   m_window = 0; end
      else if (done)  begin m_owner = 0;   m_window = (who == 1) && !da[2]; end
      else            begin m_owner = who; m_window = 0; end
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle_cycle();
    step(1, 0, 0, 0, 0, 0, 0, 0, FREE);
  endtask

  initial begin
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    model_reset();
    @(posedge CLK); #1;
    step(0, 1, 32'h10, 1, 1, 32'h20, 32'h30, 0, ACCESS);
    step(0, 0, 0, 0, 0, 0, 0, 0, FREE);
    idle_cycle();

    // lone dcache read with two BUSY cycles
    step(1, 0, 0, 1, 0, 32'h40, 0, 32'hDEADBEEF, BUSY);
    step(1, 0, 0, 1, 0, 32'h40, 0, 32'hDEADBEEF, BUSY);
    step(1, 0, 0, 1, 0, 32'h40, 0, 32'hDEADBEEF, ACCESS);
    chk("t1_window", dbg_state, 2'd3);
    step(1, 0, 0, 0, 0, 0, 0, 0, FREE);
    chk("t1_idle", dbg_state, 2'd0);

    // icache and dcache writeback burst collide
    step(1, 1, 32'h100, 0, 1, 32'h48, 32'hA5A5A5A5, 0, ACCESS);
    chk("t2_addr0", obs_addr, 32'h48);
    step(1, 1, 32'h100, 0, 1, 32'h4C, 32'h5A5A5A5A, 0, ACCESS);
    chk("t2_addr1", obs_addr, 32'h4C);
    step(1, 1, 32'h100, 0, 0, 0, 0, 32'h1234, ACCESS);
    chk("t2_ifetch", obs_addr, 32'h100);
`ifdef MEMARB_STATS_EN
    chk("t2_conflicts", conflict_cnt, 2);
`endif
    idle_cycle();

    // starvation: dcache never lets go, icache must win after LIMIT cycles
    for (int k = 0; k < LIMIT; k++)
      step(1, 1, 32'h200, 1, 0, 32'h44, 0, k, ACCESS);
    chk("t3_starve_full", dbg_starve_cnt, LIMIT);
    step(1, 1, 32'h200, 1, 0, 32'h44, 0, 32'h77, ACCESS);
    chk("t3_i_wins", obs_addr, 32'h200);
    chk("t3_starve_clear", dbg_starve_cnt, 0);
    idle_cycle();

    // abort from DBUSY
    step(1, 0, 0, 1, 0, 32'h80, 0, 0, BUSY);
    chk("t4_dbusy", dbg_state, 2'd1);
    step(1, 0, 0, 0, 0, 32'h80, 0, 0, BUSY);
    chk("t4_idle", dbg_state, 2'd0);

    // reset in the middle of an icache transfer
    step(1, 1, 32'h300, 0, 0, 0, 0, 0, BUSY);
    chk("t5_ibusy", dbg_state, 2'd2);
    step(0, 1, 32'h300, 1, 1, 32'h50, 32'h9, 0, ACCESS);
    step(1, 0, 0, 0, 0, 0, 0, 0, FREE);
    chk("t5_idle", dbg_state, 2'd0);
`ifdef MEMARB_STATS_EN
    chk("t5_dgrant_zero", dgrant_cnt, 0);
`endif

    // ERROR is not done: grant held until ACCESS
    for (int k = 0; k < 3; k++)
      step(1, 1, 32'h400, 0, 1, 32'h64, 32'hCAFE, 0, ERROR);
    step(1, 1, 32'h400, 0, 1, 32'h64, 32'hCAFE, 0, ACCESS);
    chk("t6_no_window", dbg_state, 2'd0);
    idle_cycle();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      int r;
      logic [1:0] rs;
      r  = $urandom_range(0, 5);
      rs = (r >= 3) ? ACCESS : 2'(r);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom,
           $urandom, $urandom, rs);
    end

    idle_cycle();
    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
